// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the GCD/LCM coprocessor and its decoder.
package gcd_lcm_pkg;

  localparam int unsigned GCD_WIDTH = 32;

  localparam logic [6:0] OP_GCD = 7'b0000000;
  localparam logic [6:0] OP_LCM = 7'b0000001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GCD,
    ST_DIV,
    ST_MUL,
    ST_DONE
  } gcd_state_t;

endpackage

// File: rtl/restoring_divider.sv
// Sequential restoring divider: one quotient bit per step, WIDTH steps after load.
// last_o is high during the step that produces the final quotient bit.
module restoring_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic             last_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CW-1:0]    cnt_q;
  logic             last_q;
  logic [WIDTH:0]   part_c;
  logic             fits_c;

  // Partial remainder with the next dividend bit shifted in.
  assign part_c = {rem_q, quot_q[WIDTH-1]};
  assign fits_c = part_c >= {1'b0, dvsr_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else if (load_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvsr_q <= divisor_i;
      cnt_q  <= '0;
      last_q <= (WIDTH == 1);
    end else if (step_i) begin
      cnt_q  <= cnt_q + CW'(1);
      last_q <= (cnt_q == CW'(WIDTH - 2));
      quot_q <= {quot_q[WIDTH-2:0], fits_c};
      rem_q  <= fits_c ? WIDTH'(part_c - {1'b0, dvsr_q}) : part_c[WIDTH-1:0];
    end
  end

  assign quotient_o = quot_q;
  assign last_o     = last_q;

endmodule

// File: rtl/gcd_lcm_unit.sv
// Multi-cycle GCD/LCM coprocessor: binary GCD, then LCM = (a / gcd) * b
// via a restoring divider and an inline shift-add multiplier.
module gcd_lcm_unit
  import gcd_lcm_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_lcm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int unsigned KW = $clog2(WIDTH) + 1;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  gcd_state_t       state_q;
  logic [WIDTH-1:0] a_q, b_q, x_q, y_q;
  logic             lcm_q;
  logic [KW-1:0]    k_q;
  logic [CW-1:0]    mul_cnt_q;
  logic [AW-1:0]    acc_q;
  logic             busy_q, done_q, overflow_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] g_c;
  logic [WIDTH-1:0] quot;
  logic             div_load_c, div_step_c, div_last;
  logic [AW-1:0]    acc_d;

  assign g_c        = x_q << k_q;
  assign div_load_c = (state_q == ST_GCD) && (x_q == y_q) && lcm_q;
  assign div_step_c = (state_q == ST_DIV);
  // Shift-add: add b shifted by the current quotient bit position.
  assign acc_d = quot[mul_cnt_q] ? acc_q + (AW'(b_q) << mul_cnt_q) : acc_q;

  restoring_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset      (reset),
    .load_i     (div_load_c),
    .step_i     (div_step_c),
    .dividend_i (a_q),
    .divisor_i  (g_c),
    .quotient_o (quot),
    .last_o     (div_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      lcm_q      <= 1'b0;
      k_q        <= '0;
      mul_cnt_q  <= '0;
      acc_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q        <= a;
            b_q        <= b;
            lcm_q      <= is_lcm;
            k_q        <= '0;
            overflow_q <= 1'b0;
            if (a == '0 || b == '0) begin
              result_q <= is_lcm ? '0 : (a | b);
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              x_q     <= a;
              y_q     <= b;
              busy_q  <= 1'b1;
              state_q <= ST_GCD;
            end
          end
        end
        ST_GCD: begin
          if (x_q == y_q) begin
            if (lcm_q) begin
              state_q <= ST_DIV;
            end else begin
              result_q <= g_c;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end else if (!x_q[0] && !y_q[0]) begin
            x_q <= x_q >> 1;
            y_q <= y_q >> 1;
            k_q <= k_q + KW'(1);
          end else if (!x_q[0]) begin
            x_q <= x_q >> 1;
          end else if (!y_q[0]) begin
            y_q <= y_q >> 1;
          end else if (x_q > y_q) begin
            x_q <= (x_q - y_q) >> 1;
          end else begin
            y_q <= (y_q - x_q) >> 1;
          end
        end
        ST_DIV: begin
          if (div_last) begin
            acc_q     <= '0;
            mul_cnt_q <= '0;
            state_q   <= ST_MUL;
          end
        end
        ST_MUL: begin
          acc_q     <= acc_d;
          mul_cnt_q <= mul_cnt_q + CW'(1);
          if (mul_cnt_q == CW'(WIDTH - 1)) begin
            result_q   <= acc_d[WIDTH-1:0];
            overflow_q <= |acc_d[AW-1:WIDTH];
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Self-checking bench for gcd_lcm_unit: directed cases plus random operands
// checked against an arithmetic GCD/LCM model with step-count latency.
module tb_gcd_lcm_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_lcm;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;

  int errors;
  int checks;

  gcd_lcm_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_lcm   (is_lcm),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned euclid(input longint unsigned x, input longint unsigned y);
    longint unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Number of binary-GCD steps including the final equality step (nonzero inputs).
  function automatic int stein_steps(input longint unsigned x, input longint unsigned y);
    int s;
    s = 0;
    while (x != y) begin
      s++;
      if (x % 2 == 0 && y % 2 == 0) begin
        x = x / 2;
        y = y / 2;
      end else if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0)     y = y / 2;
      else if (x > y)          x = (x - y) / 2;
      else                     y = (y - x) / 2;
    end
    return s + 1;
  endfunction

  task automatic model(input logic [31:0] oa, input logic [31:0] ob, input logic ol,
                       output logic [31:0] eres, output logic eovf, output int elat);
    longint unsigned g;
    logic [63:0]     prod;
    if (oa == 0 || ob == 0) begin
      eres = ol ? 32'd0 : (oa | ob);
      eovf = 1'b0;
      elat = 1;
    end else begin
      g = euclid(64'(oa), 64'(ob));
      if (!ol) begin
        eres = 32'(g);
        eovf = 1'b0;
        elat = 1 + stein_steps(64'(oa), 64'(ob));
      end else begin
        prod = (64'(oa) / g) * 64'(ob);
        eres = prod[31:0];
        eovf = |prod[63:32];
        elat = 1 + stein_steps(64'(oa), 64'(ob)) + 64;
      end
    end
  endtask

  // Issue one operation and check busy/done per cycle, latency, result and hold.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic ol,
                        input bit hold, input logic [31:0] eres, input logic eovf,
                        input int elat);
    int c;
    bit got;
    @(negedge clk);
    a = oa; b = ob; is_lcm = ol; start = 1'b1;
    c = 0;
    got = 0;
    while (!got && c < 400) begin
      @(negedge clk);
      c++;
      if (done) got = 1;
      else if (c < elat) chk("busy_during_op", 64'(busy), 64'd1);
      if (c == 1 && !hold) begin
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        is_lcm = ~ol;
      end
    end
    chk("done_cycle", 64'(c), 64'(elat));
    if (got) begin
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("result", 64'(result), 64'(eres));
      chk("overflow", 64'(overflow), 64'(eovf));
    end
    @(negedge clk);
    chk("idle_done_low", 64'(done), 64'd0);
    chk("idle_busy_low", 64'(busy), 64'd0);
    chk("result_held", 64'(result), 64'(eres));
  endtask

  initial begin
    logic [31:0] eres, oa, ob, m;
    logic        eovf, ol;
    int          elat, mode;

    errors = 0;
    checks = 0;
    clk    = 1'b0;
    reset  = 1'b1;
    start  = 1'b0;
    is_lcm = 1'b0;
    a      = '0;
    b      = '0;

    // Model pinned to hand-computed values.
    chk("pin_steps_12_18", 64'(stein_steps(64'd12, 64'd18)), 64'd4);
    chk("pin_gcd_12_18", euclid(64'd12, 64'd18), 64'd6);
    model(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, eres, eovf, elat);
    chk("pin_lcm_max_res", 64'(eres), 64'd2);
    chk("pin_lcm_max_ovf", 64'(eovf), 64'd1);
    chk("pin_steps_bound", 64'(elat - 65 <= 65), 64'd1);

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;

    run_op(32'd12, 32'd18, 1'b0, 0, 32'd6, 1'b0, 5);
    run_op(32'd12, 32'd18, 1'b1, 0, 32'd36, 1'b0, 69);
    run_op(32'd0, 32'd7, 1'b0, 0, 32'd7, 1'b0, 1);
    run_op(32'd0, 32'd7, 1'b1, 0, 32'd0, 1'b0, 1);
    run_op(32'd0, 32'd0, 1'b0, 0, 32'd0, 1'b0, 1);
    model(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, eres, eovf, elat);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 0, 32'd2, 1'b1, elat);

    // Reset asserted in cycle 40 of an LCM discards it.
    @(negedge clk);
    a = 32'd12; b = 32'd18; is_lcm = 1'b1; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      chk("busy_before_reset", 64'(busy), 64'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midop_rst_busy", 64'(busy), 64'd0);
    chk("midop_rst_done", 64'(done), 64'd0);
    chk("midop_rst_result", 64'(result), 64'd0);
    chk("midop_rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    run_op(32'd9, 32'd6, 1'b0, 0, 32'd3, 1'b0, 4);

    // start held through GCD(8,8) and DONE: one pulse, re-accepted in next IDLE.
    run_op(32'd8, 32'd8, 1'b0, 1, 32'd8, 1'b0, 2);
    @(negedge clk);
    chk("hold_reaccept_busy", 64'(busy), 64'd1);
    chk("hold_reaccept_done", 64'(done), 64'd0);
    start = 1'b0;
    @(negedge clk);
    chk("hold_second_done", 64'(done), 64'd1);
    chk("hold_second_result", 64'(result), 64'd8);
    @(negedge clk);
    chk("hold_idle_done", 64'(done), 64'd0);

    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin
          oa = $urandom_range(0, 40);
          ob = $urandom_range(0, 40);
        end
        1: begin
          oa = $urandom;
          ob = $urandom;
        end
        2: begin
          m  = $urandom_range(1, 1000);
          oa = m * $urandom_range(0, 5000);
          ob = m * $urandom_range(0, 5000);
        end
        default: begin
          oa = 32'($urandom_range(1, 255)) << $urandom_range(0, 20);
          ob = 32'($urandom_range(1, 255)) << $urandom_range(0, 20);
        end
      endcase
      ol = 1'($urandom_range(0, 1));
      model(oa, ob, ol, eres, eovf, elat);
      run_op(oa, ob, ol, 0, eres, eovf, elat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
